// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module      : fetch_queue_if
// Description : Instruction-ROM port, redirect and delivery handshake
//               signals of the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Fetch stage - owns the PC, issues ROM requests and buffers
//               fetched {pc, instr} pairs in a small FIFO for execute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire             clk,
  input  wire             rst_n,
  fetch_queue_if.master   bus
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  c_DEPTH = (CNT_W+1)'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic             r_inflight;
  logic [31:0]      r_inflight_pc;
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W:0]   w_used;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_target;

  // Each in-flight fetch holds a reserved slot, so the FIFO can never overflow.
  assign w_used   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue  = !bus.redirect && (w_used < c_DEPTH);
  assign w_push   = r_inflight && !bus.redirect;
  assign w_pop    = (r_count != '0) && bus.out_ready && !bus.redirect;
  assign w_target = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + 32'd4;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 64'h0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {r_inflight_pc, bus.imem_data};
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_fetch_pc[ADDR_W-1:0];
  assign bus.out_valid = (r_count != '0);
  assign bus.out_instr = r_mem[r_rd_ptr][31:0];
  assign bus.out_pc    = r_mem[r_rd_ptr][63:32];
  assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue against a queue-based
//               model of the fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: PCs held in the FIFO, the in-flight fetch and the next PC.
  logic [31:0] m_q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {18'd0, pc[15:2]};
  endfunction

  // Synchronous ROM; returns garbage when not requested.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_data <= rom_word({16'h0, bus.imem_addr});
    else              bus.imem_data <= $urandom;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s observed=timeout expected=condition", tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl    = 1'b0;
    m_infl_pc = 32'h0;
    m_fpc     = RESET_PC;
  endtask

  // One clock cycle: drive, check combinational/registered outputs, advance model.
  task automatic step(input logic red, input logic [31:0] rpc, input logic rdy);
    bit m_req;
    @(negedge clk);
    bus.redirect    = red;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    #1;
    m_req = !red && ((m_q.size() + int'(m_infl)) < DEPTH);
    check("imem_req", 64'(bus.imem_req), 64'(m_req));
    if (m_req) check("imem_addr", 64'(bus.imem_addr), 64'(m_fpc[15:0]));
    check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    check("count", 64'(bus.count), 64'(m_q.size()));
    if (m_q.size() != 0) begin
      check("out_pc", 64'(bus.out_pc), 64'(m_q[0]));
      check("out_instr", 64'(bus.out_instr), 64'(rom_word(m_q[0])));
    end
    @(posedge clk);
    if (red) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fpc  = {rpc[31:2], 2'b00};
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (m_req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  initial begin
    bit done;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;
    rst_n = 1'b1;

    // Reset state, observed without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_pc", 64'(bus.out_pc), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Steady stream with out_ready held high
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

    // Backpressure, then release
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // Reach count=3 with a fetch in flight, then redirect
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_q.size() == 3 && m_infl) done = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    if (!done) timeout_fail("wait_count3_inflight");
    step(1'b1, 32'h0000_0102, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect while the head is being accepted
    step(1'b1, 32'h0000_2000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Random ready / occasional redirect
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15, 0) == 0) step(1'b1, $urandom, 1'($urandom));
      else                            step(1'b0, 32'h0, 1'($urandom));
    end

    // Async reset mid-stream with count=2
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_q.size() == 2) done = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    if (!done) timeout_fail("wait_count2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_pc", 64'(bus.out_pc), 64'd0);
    check("arst_out_instr", 64'(bus.out_instr), 64'd0);
    check("arst_count", 64'(bus.count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage for the two-stage core: owns the program counter, issues requests to the synchronous instruction ROM, and buffers fetched instructions with their PCs in a small FIFO. The execute stage consumes these through a valid/ready handshake and redirects fetch on taken branches and jumps. This replaces the bare PC register so that execute can stall (e.g. for multi-cycle RAM access) without losing instructions.

## Interface
- ADDR_W, 16, ROM address width; `imem_addr` carries the low ADDR_W bits of the byte PC
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch issued this cycle (combinational)
- imem_addr  out  ADDR_W  byte address of the fetch, equal to fetch_pc[ADDR_W-1:0]
- imem_data  in  32  ROM word; valid in the cycle after a request, fixed 1-cycle latency
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  head entry valid
- out_ready  in  1  execute accepts head this cycle
- out_instr  out  32  instruction at head
- out_pc  out  32  PC of instruction at head
- count  out  $clog2(DEPTH)+1  entries currently stored

## Operation
- State: fetch_pc (32), inflight flag plus inflight_pc (32), FIFO storage (DEPTH × 64), read/write pointers, count.
- Issue rule: imem_req = !redirect && (count + inflight < DEPTH). Credit is computed from the current count; a pop in the same cycle does not free a credit for that cycle.
- On an issued request: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32). No request: inflight <= 0.
- Push: when inflight=1 and no redirect, {inflight_pc, imem_data} is written at the write pointer.
- Pop: when out_valid && out_ready, read pointer advances. Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH and never exceeds DEPTH, because the issue rule reserves a slot per in-flight fetch.
- Redirect (highest priority): FIFO emptied (count <= 0, pointers reset), inflight squashed (<= 0, ROM data returned this cycle discarded), fetch_pc <= {redirect_pc[31:2], 2'b00}. Any pop in the same cycle is ignored; the head is discarded regardless of out_ready.
- out_valid = (count != 0). out_instr/out_pc show head storage and are meaningful only while out_valid=1.

## Timing
- Reset (async, immediate): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, storage=0, therefore out_valid=0, out_instr=0, out_pc=0, imem_req=1 while reset is deasserted and redirect=0.
- Fetch latency: request in cycle N produces ROM data in N+1, a push at the end of N+1, and out_valid=1 in N+2.
- Redirect asserted in cycle R: imem_req=0 in R; redirect_pc is requested in R+1; out_valid=1 with out_pc=redirect_pc in R+3 (3-cycle penalty).
- Steady state with out_ready held at 1: one instruction per cycle, consecutive PCs +4.
- With out_ready=0 from cycle N: requests stop once count + inflight = DEPTH; no instruction is lost or duplicated.
- Reset asserted mid-operation clears everything, including in-flight data; the first cycle after deassertion requests RESET_PC.

## Test plan
- Reset release with ROM word[i] = 32'h1000_0000+i and out_ready=1: out_pc sequence 0,4,8,... first valid 2 cycles after the first request; one pop per cycle; count stays at 1.
- Backpressure: out_ready=0 for 10 cycles after reset: count saturates at 4, imem_req=0 once count + inflight = 4, and on release the pops are PCs 0,4,8,12,16,... with no gap or repeat.
- Redirect to 32'h0000_0102 while count=3 and inflight=1: count=0 next cycle, the in-flight word is dropped, imem_req=0 in the redirect cycle, and the next out_pc is 32'h0000_0100 valid 3 cycles later.
- Redirect with out_valid=1 and out_ready=1 in the same cycle: the head is not counted as delivered, and only the redirect-target stream follows.
- fetch_pc=32'hFFFF_FFFC via redirect: the following PCs are FFFF_FFFC, then 0000_0000; imem_addr = 16'hFFFC, then 16'h0000.
- Async reset pulse mid-stream (count=2): outputs are zero immediately without a clock edge, and after release the stream restarts at RESET_PC.
